// File: rtl/pb_led_io.sv
// Push-button/LED I/O block: synchronised, debounced buttons with edge
// pulses and sticky press flags; LED register with per-bit blink.
`timescale 1ns/1ps
module pb_led_io #(
   parameter int unsigned NUM_PB     = 5,
   parameter int unsigned NUM_LED    = 12,
   parameter int unsigned DEB_CYCLES = 1000,
   parameter int unsigned DEB_W      = 16,
   parameter int unsigned BLINK_DIV  = 25000000,
   parameter int unsigned BLINK_W    = 25
) (
   input  logic               clk,
   input  logic               rst,
   input  logic [NUM_PB-1:0]  pb_in,
   output logic [NUM_PB-1:0]  pb_level,
   output logic [NUM_PB-1:0]  pb_press,
   output logic [NUM_PB-1:0]  pb_release,
   output logic [NUM_PB-1:0]  evt_flags,
   input  logic               evt_clr,
   input  logic [NUM_PB-1:0]  evt_clr_mask,
   input  logic               led_we,
   input  logic [NUM_LED-1:0] led_wdata,
   input  logic               blink_we,
   input  logic [NUM_LED-1:0] blink_wdata,
   output logic [NUM_LED-1:0] led
);

   localparam logic [DEB_W-1:0]   DEB_LAST   = DEB_W'(DEB_CYCLES - 1);
   localparam logic [BLINK_W-1:0] BLINK_LAST = BLINK_W'(BLINK_DIV - 1);

   logic [NUM_PB-1:0]             s1;
   logic [NUM_PB-1:0]             s2;
   logic [NUM_PB-1:0][DEB_W-1:0]  cnt;
   logic [NUM_PB-1:0][DEB_W-1:0]  cnt_next;
   logic [NUM_PB-1:0]             level_next;
   logic [NUM_PB-1:0]             press_next;
   logic [NUM_PB-1:0]             release_next;
   logic [NUM_PB-1:0]             flags_next;

   logic [NUM_LED-1:0]            led_val;
   logic [NUM_LED-1:0]            blink_mask;
   logic [BLINK_W-1:0]            pcnt;
   logic                          phase;

   // Per-channel debounce decision and sticky-flag update (set wins over clear)
   always_comb begin
      level_next   = pb_level;
      press_next   = '0;
      release_next = '0;
      cnt_next     = '0;
      for (int unsigned i = 0; i < NUM_PB; i++) begin
         if (s2[i] != pb_level[i]) begin
            if (cnt[i] == DEB_LAST) begin
               level_next[i]   = s2[i];
               press_next[i]   = s2[i];
               release_next[i] = ~s2[i];
            end else begin
               cnt_next[i] = cnt[i] + 1'b1;
            end
         end
      end
      flags_next = (evt_flags & ~({NUM_PB{evt_clr}} & evt_clr_mask)) | press_next;
   end

   // Synchroniser, debounce state, pulses and event flags
   always_ff @(posedge clk) begin
      if (rst) begin
         s1         <= '0;
         s2         <= '0;
         cnt        <= '0;
         pb_level   <= '0;
         pb_press   <= '0;
         pb_release <= '0;
         evt_flags  <= '0;
      end else begin
         s1         <= pb_in;
         s2         <= s1;
         cnt        <= cnt_next;
         pb_level   <= level_next;
         pb_press   <= press_next;
         pb_release <= release_next;
         evt_flags  <= flags_next;
      end
   end

   // LED value/blink registers, free-running prescaler and registered LED drive
   always_ff @(posedge clk) begin
      if (rst) begin
         led_val    <= '0;
         blink_mask <= '0;
         pcnt       <= '0;
         phase      <= 1'b0;
         led        <= '0;
      end else begin
         if (led_we)   led_val    <= led_wdata;
         if (blink_we) blink_mask <= blink_wdata;
         if (pcnt == BLINK_LAST) begin
            pcnt  <= '0;
            phase <= ~phase;
         end else begin
            pcnt <= pcnt + 1'b1;
         end
         led <= led_val & ~(blink_mask & {NUM_LED{phase}});
      end
   end

endmodule
